// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit.
// Holds the RV32I B-format funct3 encodings, the decoded branch-op enum
// and the helper function that maps a funct3 value to a branch op.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        OP_EQ  = 3'd0,
        OP_NE  = 3'd1,
        OP_LT  = 3'd2,
        OP_GE  = 3'd3,
        OP_LTU = 3'd4,
        OP_GEU = 3'd5,
        OP_ILL = 3'd6
    } br_op_e;

    // 010 and 011 are not branch encodings and decode to OP_ILL.
    function automatic br_op_e decode_funct3(input logic [2:0] f3);
        br_op_e op;
        case (f3)
            F3_BEQ:  op = OP_EQ;
            F3_BNE:  op = OP_NE;
            F3_BLT:  op = OP_LT;
            F3_BGE:  op = OP_GE;
            F3_BLTU: op = OP_LTU;
            F3_BGEU: op = OP_GEU;
            default: op = OP_ILL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational operand comparator for branch resolution.
// Ports:
//   a_i, b_i     operands (XLEN bits)
//   unsigned_i   1 = unsigned less-than, 0 = signed less-than
//   eq_o         a_i == b_i
//   lt_o         a_i < b_i under the selected signedness
module branch_cmp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            unsigned_i,
    output logic            eq_o,
    output logic            lt_o
);

    always_comb begin
        eq_o = (a_i == b_i);
        if (unsigned_i) begin
            lt_o = (a_i < b_i);
        end else begin
            lt_o = ($signed(a_i) < $signed(b_i));
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution unit: decodes funct3, compares operands, decides the
// branch direction, flags a mispredict and produces the corrected next PC.
// Results sit in a single output register (1-cycle latency) behind a
// valid/ready handshake, with saturating statistics counters.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         request handshake
//   in_funct3, in_rs1/rs2     branch type and compare operands
//   in_pc, in_imm             branch PC and sign-extended offset
//   in_pred_taken             front-end prediction
//   flush                     drop held result and any incoming request
//   out_valid/out_ready       result handshake
//   out_taken/redirect/illegal, out_redirect_pc   registered result
//   cnt_branch, cnt_mispred   saturating statistics counters
module branch_resolve
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_redirect,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             valid_q,    valid_d;
    logic             taken_q,    taken_d;
    logic             redirect_q, redirect_d;
    logic             illegal_q,  illegal_d;
    logic [XLEN-1:0]  rpc_q,      rpc_d;
    logic [CNT_W-1:0] cnt_br_q,   cnt_br_d;
    logic [CNT_W-1:0] cnt_mp_q,   cnt_mp_d;

    br_op_e          op;
    logic            cmp_unsigned;
    logic            cmp_eq;
    logic            cmp_lt;
    logic            taken_c;
    logic            illegal_c;
    logic            redirect_c;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fallthrough;
    logic            accept;
    logic            out_hs;
    logic            count_en;

    assign op           = decode_funct3(in_funct3);
    assign cmp_unsigned = (op == OP_LTU) || (op == OP_GEU);

    branch_cmp #(
        .XLEN(XLEN)
    ) u_cmp (
        .a_i       (in_rs1),
        .b_i       (in_rs2),
        .unsigned_i(cmp_unsigned),
        .eq_o      (cmp_eq),
        .lt_o      (cmp_lt)
    );

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (op)
            OP_EQ:   taken_c = cmp_eq;
            OP_NE:   taken_c = !cmp_eq;
            OP_LT,
            OP_LTU:  taken_c = cmp_lt;
            OP_GE,
            OP_GEU:  taken_c = !cmp_lt;
            default: illegal_c = 1'b1;
        endcase
    end

    assign target      = in_pc + in_imm;
    assign fallthrough = in_pc + XLEN'(4);
    // An illegal op never redirects, whatever the prediction said.
    assign redirect_c  = !illegal_c && (taken_c ^ in_pred_taken);

    // No skid buffer: ready simply follows the output register's state.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_hs   = valid_q && out_ready;
    assign count_en = out_hs && !illegal_q;

    always_comb begin
        valid_d    = valid_q;
        taken_d    = taken_q;
        redirect_d = redirect_q;
        illegal_d  = illegal_q;
        rpc_d      = rpc_q;
        cnt_br_d   = cnt_br_q;
        cnt_mp_d   = cnt_mp_q;

        if (flush) begin
            // Flush discards both the held result (uncounted) and any
            // request accepted in this cycle.
            valid_d = 1'b0;
        end else begin
            if (count_en) begin
                if (cnt_br_q != CNT_MAX) begin
                    cnt_br_d = cnt_br_q + CNT_W'(1);
                end
                if (redirect_q && (cnt_mp_q != CNT_MAX)) begin
                    cnt_mp_d = cnt_mp_q + CNT_W'(1);
                end
            end
            if (accept) begin
                valid_d    = 1'b1;
                taken_d    = taken_c;
                redirect_d = redirect_c;
                illegal_d  = illegal_c;
                rpc_d      = taken_c ? target : fallthrough;
            end else if (out_hs) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            taken_q    <= 1'b0;
            redirect_q <= 1'b0;
            illegal_q  <= 1'b0;
            rpc_q      <= '0;
            cnt_br_q   <= '0;
            cnt_mp_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            taken_q    <= taken_d;
            redirect_q <= redirect_d;
            illegal_q  <= illegal_d;
            rpc_q      <= rpc_d;
            cnt_br_q   <= cnt_br_d;
            cnt_mp_q   <= cnt_mp_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_taken       = taken_q;
    assign out_redirect    = redirect_q;
    assign out_illegal     = illegal_q;
    assign out_redirect_pc = rpc_q;
    assign cnt_branch      = cnt_br_q;
    assign cnt_mispred     = cnt_mp_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Testbench for branch_resolve (XLEN=32, CNT_W=4 so saturation is reachable).
module tb_branch_resolve;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_rs1, in_rs2, in_pc, in_imm;
    logic             in_pred_taken;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken, out_redirect, out_illegal;
    logic [XLEN-1:0]  out_redirect_pc;
    logic [CNT_W-1:0] cnt_branch, cnt_mispred;

    always #5 clk = ~clk;

    branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_funct3      (in_funct3),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_redirect   (out_redirect),
        .out_illegal    (out_illegal),
        .out_redirect_pc(out_redirect_pc),
        .cnt_branch     (cnt_branch),
        .cnt_mispred    (cnt_mispred)
    );

    typedef struct {
        logic        taken;
        logic        redirect;
        logic        illegal;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   mdl_br   = 0;
    int   mdl_mp   = 0;
    bit   armed    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        exp_t e;
        logic t;
        logic ill;
        t   = 1'b0;
        ill = 1'b0;
        case (f3)
            3'b000: t = (a == b);
            3'b001: t = (a != b);
            3'b100: t = ($signed(a) < $signed(b));
            3'b101: t = ($signed(a) >= $signed(b));
            3'b110: t = (a < b);
            3'b111: t = (a >= b);
            default: ill = 1'b1;
        endcase
        e.taken    = t;
        e.illegal  = ill;
        e.redirect = ill ? 1'b0 : (t ^ pred);
        e.rpc      = t ? (pc + imm) : (pc + 32'd4);
        return e;
    endfunction

    // Scoreboard monitor: pushes on acceptance, pops on output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (armed) begin
                check("cnt_branch", 32'(cnt_branch), 32'(mdl_br));
                check("cnt_mispred", 32'(cnt_mispred), 32'(mdl_mp));
                if (!rst && !flush && out_valid === 1'b1 && out_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check("taken", 32'(out_taken), 32'(e.taken));
                        check("redirect", 32'(out_redirect), 32'(e.redirect));
                        check("illegal", 32'(out_illegal), 32'(e.illegal));
                        check("redirect_pc", out_redirect_pc, e.rpc);
                        if (!e.illegal) begin
                            if (mdl_br < CMAX) mdl_br++;
                            if (e.redirect && mdl_mp < CMAX) mdl_mp++;
                        end
                    end
                end
            end
            if (rst || flush) begin
                sb.delete();
            end else if (in_valid && in_ready === 1'b1) begin
                sb.push_back(model(in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken));
            end
            if (rst) begin
                mdl_br = 0;
                mdl_mp = 0;
                armed  = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        in_valid      = 1'b1;
        in_funct3     = f3;
        in_rs1        = a;
        in_rs2        = b;
        in_pc         = pc;
        in_imm        = imm;
        in_pred_taken = pred;
    endtask

    initial begin
        bit accepted;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_funct3 = 3'b000; in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0; in_pred_taken = 1'b0;
        step(); step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_redirect_pc", out_redirect_pc, 32'd0);
        check("rst_cnt_branch", 32'(cnt_branch), 32'd0);
        rst = 1'b0;
        step();

        // BLT signed: -1 < 1 taken, predicted not-taken.
        drive(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0);
        step();
        in_valid = 1'b0;
        check("blt_valid", 32'(out_valid), 32'd1);
        check("blt_taken", 32'(out_taken), 32'd1);
        check("blt_redirect", 32'(out_redirect), 32'd1);
        check("blt_pc", out_redirect_pc, 32'h120);
        step();
        check("blt_cnt_mp", 32'(cnt_mispred), 32'd1);

        // BLTU: 0xFFFFFFFF < 1 false, predicted taken.
        drive(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b1);
        step();
        in_valid = 1'b0;
        check("bltu_taken", 32'(out_taken), 32'd0);
        check("bltu_redirect", 32'(out_redirect), 32'd1);
        check("bltu_pc", out_redirect_pc, 32'h104);
        step();
        check("bltu_cnt_mp", 32'(cnt_mispred), 32'd2);
        check("bltu_cnt_br", 32'(cnt_branch), 32'd2);

        // Backpressure: A held 3 cycles with B pending, then 1/cycle.
        out_ready = 1'b0;
        drive(3'b000, 32'd5, 32'd5, 32'h200, 32'h10, 1'b1);
        step();
        drive(3'b001, 32'd3, 32'd3, 32'h300, 32'h8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_taken", 32'(out_taken), 32'd1);
            check("stall_pc", out_redirect_pc, 32'h210);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        step();
        check("b2b_pc_b", out_redirect_pc, 32'h304);
        drive(3'b101, 32'hFFFF_FFFE, 32'd1, 32'h400, 32'hFFFF_FFF0, 1'b1);
        step();
        in_valid = 1'b0;
        check("b2b_pc_c", out_redirect_pc, 32'h404);
        check("b2b_redirect_c", 32'(out_redirect), 32'd1);
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("b2b_cnt_br", 32'(cnt_branch), 32'd5);
        check("b2b_cnt_mp", 32'(cnt_mispred), 32'd3);

        // Illegal funct3.
        drive(3'b010, 32'd1, 32'd1, 32'h500, 32'h40, 1'b1);
        step();
        in_valid = 1'b0;
        check("ill_illegal", 32'(out_illegal), 32'd1);
        check("ill_taken", 32'(out_taken), 32'd0);
        check("ill_redirect", 32'(out_redirect), 32'd0);
        step();
        check("ill_cnt_br", 32'(cnt_branch), 32'd5);
        check("ill_cnt_mp", 32'(cnt_mispred), 32'd3);

        // Flush with a held result and a new request in the same cycle.
        out_ready = 1'b0;
        drive(3'b111, 32'd1, 32'd2, 32'h600, 32'h8, 1'b1);
        step();
        drive(3'b000, 32'd7, 32'd7, 32'h700, 32'h8, 1'b0);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        step();
        check("flush_cnt_br", 32'(cnt_branch), 32'd5);
        check("flush_cnt_mp", 32'(cnt_mispred), 32'd3);

        // Random traffic with random backpressure; scoreboard checks results.
        for (int i = 0; i < 24; i++) begin
            drive(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom,
                  32'($urandom_range(0, 4)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            accepted = 0;
            for (int t = 0; t < 40 && !accepted; t++) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                accepted = (in_ready === 1'b1);
                step();
            end
            if (!accepted) check("rand_accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(); step();
        check("rand_sb_empty", 32'(sb.size()), 32'd0);

        // Saturation: reset, then 17 mispredicting branches.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("sat_start_br", 32'(cnt_branch), 32'd0);
        drive(3'b000, 32'd1, 32'd1, 32'h800, 32'h10, 1'b0);
        for (int i = 0; i < 17; i++) step();
        in_valid = 1'b0;
        step(); step();
        check("sat_cnt_br", 32'(cnt_branch), 32'd15);
        check("sat_cnt_mp", 32'(cnt_mispred), 32'd15);
        check("sat_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/PC width (min 8).
REQ-002 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have port in_funct3  input  3  branch type, RV32I B-format encoding.
REQ-008 SHALL have port in_rs1, in_rs2  input  XLEN each  compare operands.
REQ-009 SHALL have port in_pc, in_imm  input  XLEN each  branch PC, sign-extended offset.
REQ-010 SHALL have port in_pred_taken  input  1  front-end prediction.
REQ-011 SHALL have port flush  input  1  discard held and incoming requests.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have ports out_taken, out_redirect, out_illegal  output  1 each  resolved direction, mispredict, bad funct3.
REQ-015 SHALL have port out_redirect_pc  output  XLEN  correct next PC.
REQ-016 SHALL have ports cnt_branch, cnt_mispred  output  CNT_W each  statistics.

Function
REQ-017 SHALL decode funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
REQ-018 SHALL treat funct3 010/011 as illegal: taken=0, illegal=1, redirect=0, not counted.
REQ-019 SHALL compute target = in_pc + in_imm and fallthrough = in_pc + 4, both modulo 2^XLEN.
REQ-020 SHALL set redirect = taken XOR pred_taken; redirect_pc = taken ? target : fallthrough.
REQ-021 SHALL register all results in one output stage: latency exactly 1 cycle from acceptance.
REQ-022 SHALL drive in_ready = !out_valid || out_ready (combinational, no skid buffer).
REQ-023 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-024 SHALL accept a new request in the same cycle the held result is consumed (full throughput).
REQ-025 SHALL clear out_valid next cycle when flush=1 and drop any request accepted that cycle.
REQ-026 SHALL update counters only on output handshake (out_valid && out_ready) of a legal result.
REQ-027 SHALL increment cnt_branch per counted result and cnt_mispred when out_redirect=1.
REQ-028 SHALL saturate both counters at 2^CNT_W-1; no wrap.
REQ-029 SHALL give flush priority over counter update of a result handshaken in the same cycle (not counted).

Reset
REQ-030 SHALL on rst=1 clear out_valid, out_taken, out_redirect, out_illegal, out_redirect_pc, cnt_branch, cnt_mispred to 0 next edge.
REQ-031 SHALL hold in_ready=1 while out_valid=0, including during reset.
REQ-032 SHALL give rst priority over flush and handshake; requests presented with rst=1 are dropped.

Structure
REQ-033 SHALL place funct3 encoding constants and a branch-op enum in shared package branch_pkg.
REQ-034 SHALL instantiate one sub-module branch_cmp (combinational, XLEN-parametrised, outputs eq and lt with unsigned select).
REQ-035 SHALL keep handshake register, redirect logic and counters in branch_resolve; no other sub-modules.

Verification
REQ-036 SHALL test BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20, pred=0 -> next cycle taken=1, redirect=1, redirect_pc=0x120.
REQ-037 SHALL test BLTU same operands, pred=1 -> taken=0, redirect=1, redirect_pc=0x104, cnt_mispred increments on handshake.
REQ-038 SHALL test out_ready=0 for 3 cycles with second request pending -> outputs stable, in_ready=0, then back-to-back acceptance at 1/cycle.
REQ-039 SHALL test funct3=010 -> illegal=1, taken=0, counters unchanged.
REQ-040 SHALL test flush asserted with out_valid=1 and new in_valid=1 -> out_valid=0 next cycle, neither request counted.
REQ-041 SHALL test CNT_W=4, 17 mispredicting branches -> both counters read 15.
